// File: rtl/data_demux_buffered_if.sv
// Bundle for the buffered 1:2 demux: the producer-side input stream plus the
// two consumer-side output channels with their occupancy levels.
interface data_demux_buffered_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] InData;
  logic             InValid;
  logic             Selector;
  logic             InReady;

  logic [WIDTH-1:0] Output0;
  logic             Output0Valid;
  logic             Output0Ready;
  logic [WIDTH-1:0] Output1;
  logic             Output1Valid;
  logic             Output1Ready;

  logic [LW-1:0]    Level0;
  logic [LW-1:0]    Level1;

  // Environment side: producer and both consumers.
  modport master (
    output InData, InValid, Selector, Output0Ready, Output1Ready,
    input  InReady, Output0, Output0Valid, Output1, Output1Valid, Level0, Level1
  );

  // Demux side.
  modport slave (
    input  InData, InValid, Selector, Output0Ready, Output1Ready,
    output InReady, Output0, Output0Valid, Output1, Output1Valid, Level0, Level1
  );
endinterface

// File: rtl/data_demux_buffered.sv
// Routes one input word stream to one of two output channels, each buffered by
// its own small FIFO so a stalled consumer does not block the other channel.
module data_demux_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  data_demux_buffered_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [LW-1:0]    level  [2];

  logic [1:0] out_ready;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] not_full;

  assign out_ready = {bus.Output1Ready, bus.Output0Ready};

  // A full channel refuses input even while draining; this keeps the consumer
  // ready signals off the combinational path to InReady.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int c = 0; c < 2; c++) begin
      not_full[c] = (level[c] < FULL);
      pop[c]      = (level[c] != '0) && out_ready[c];
    end
    bus.InReady = bus.Selector ? not_full[1] : not_full[0];
    if (bus.InValid && bus.InReady) push[bus.Selector] = 1'b1;
  end

  // NOTE: storage carries no reset; the pointers and levels alone define which
  // entries are live, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= bus.InData;
  end

  // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        level[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
        case ({push[c], pop[c]})
          2'b10:   level[c] <= level[c] + LW'(1);
          2'b01:   level[c] <= level[c] - LW'(1);
          default: level[c] <= level[c];
        endcase
      end
    end
  end

  // Empty channels drive zero, matching the mux's default output.
  assign bus.Output0Valid = (level[0] != '0);
  assign bus.Output1Valid = (level[1] != '0);
  assign bus.Output0      = bus.Output0Valid ? mem[0][rd_ptr[0]] : '0;
  assign bus.Output1      = bus.Output1Valid ? mem[1][rd_ptr[1]] : '0;
  assign bus.Level0       = level[0];
  assign bus.Level1       = level[1];

endmodule

// File: tb/tb_data_demux_buffered.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the two channels.
module tb_data_demux_buffered;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  bit   checking = 1'b0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  data_demux_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  data_demux_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, compare outputs with the model state left by the
  // previous edge, then advance the model as the coming edge will.
  task automatic cycle(input bit rst, input bit vld, input logic [WIDTH-1:0] data,
                       input bit sel, input bit r0, input bit r1);
    bit rdy, pop0, pop1;
    @(negedge clk);
    reset_n          = ~rst;
    bus.InValid      = vld;
    bus.InData       = data;
    bus.Selector     = sel;
    bus.Output0Ready = r0;
    bus.Output1Ready = r1;
    #1;
    rdy = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    if (checking) begin
      check("InReady", 32'(bus.InReady), 32'(rdy));
      check("Output0Valid", 32'(bus.Output0Valid), 32'(q0.size() != 0));
      check("Output1Valid", 32'(bus.Output1Valid), 32'(q1.size() != 0));
      check("Level0", 32'(bus.Level0), 32'(q0.size()));
      check("Level1", 32'(bus.Level1), 32'(q1.size()));
      check("Output0", bus.Output0, (q0.size() != 0) ? q0[0] : '0);
      check("Output1", bus.Output1, (q1.size() != 0) ? q1[0] : '0);
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      checking = 1'b1;
    end else begin
      pop0 = r0 && (q0.size() != 0);
      pop1 = r1 && (q1.size() != 0);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (vld && rdy) begin
        if (sel) q1.push_back(data);
        else     q0.push_back(data);
      end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.InValid      = 1'b0;
    bus.InData       = '0;
    bus.Selector     = 1'b0;
    bus.Output0Ready = 1'b0;
    bus.Output1Ready = 1'b0;

    // Reset held for two edges with a word offered: nothing may be captured.
    cycle(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    cycle(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
    cycle(0, 0, '0, 0, 0, 0);

    // Basic routing.
    cycle(0, 1, 32'h1111_1111, 0, 1, 1);
    cycle(0, 1, 32'h2222_2222, 1, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);

    // Fill channel 0, hold A2 against backpressure, route B0 to channel 1.
    cycle(0, 1, 32'hA0, 0, 0, 0);
    cycle(0, 1, 32'hA1, 0, 0, 0);
    cycle(0, 1, 32'hA2, 0, 0, 0);
    cycle(0, 1, 32'hA2, 0, 0, 0);
    cycle(0, 1, 32'hB0, 1, 0, 0);
    // Drain channel 0 while A2 waits; order A0, A1, A2.
    cycle(0, 1, 32'hA2, 0, 1, 0);
    cycle(0, 1, 32'hA2, 0, 1, 0);
    cycle(0, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);
    cycle(0, 0, '0, 0, 1, 1);

    // Streaming with concurrent pop: pointers wrap several times.
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'hC000_0000 + i, 1, 0, 1);
    cycle(0, 0, '0, 0, 0, 1);
    cycle(0, 0, '0, 0, 0, 1);

    // Reset mid-operation with Level0=2, Level1=1 and a push in flight.
    cycle(0, 1, 32'hD0, 0, 0, 0);
    cycle(0, 1, 32'hD1, 0, 0, 0);
    cycle(0, 1, 32'hE0, 1, 0, 0);
    cycle(0, 0, '0, 0, 0, 0);
    check("Level0_before_reset", 32'(bus.Level0), 32'd2);
    check("Level1_before_reset", 32'(bus.Level1), 32'd1);
    cycle(1, 1, 32'hE1, 1, 0, 0);
    cycle(0, 0, '0, 0, 0, 0);
    cycle(0, 0, '0, 0, 1, 1);

    // Random traffic with independent consumer stalls and the odd reset.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 2) == 0));
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_demux_buffered.md
Name: data_demux_buffered

Overview:
- Inverse of the datapath 2:1 data mux: routes one 32-bit input stream to one of two output channels.
- The destination is chosen per word by a 1-bit Selector.
- Each output channel has its own small FIFO with a valid/ready handshake, so a stalled consumer on one channel does not block traffic to the other once the input word targets the free channel.
- Sits between a producer stage (for example write-back or bus response) and two consumers (for example register file and memory/IO path).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- InData  input  WIDTH  word presented by the producer.
- InValid  input  1  producer has a word on InData.
- Selector  input  1  destination of the presented word: 0 routes to channel 0, 1 routes to channel 1.
- InReady  output  1  the selected channel can accept the word this cycle.
- Output0  output  WIDTH  channel 0 head word.
- Output0Valid  output  1  channel 0 FIFO non-empty.
- Output0Ready  input  1  channel 0 consumer takes the head this cycle.
- Output1  output  WIDTH  channel 1 head word.
- Output1Valid  output  1  channel 1 FIFO non-empty.
- Output1Ready  input  1  channel 1 consumer takes the head this cycle.
- Level0  output  clog2(DEPTH)+1  channel 0 occupancy.
- Level1  output  clog2(DEPTH)+1  channel 1 occupancy.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-low (reset_n); it is sampled only on a rising clk edge.
- Reset, when reset_n=0 at a clk edge:
  - Both FIFOs emptied; read/write pointers and levels cleared to 0.
  - Output0Valid=0, Output1Valid=0, Level0=0, Level1=0.
  - Reset overrides any simultaneous push or pop. A word in flight at reset is discarded, and reset mid-stream loses all buffered words.
- InReady:
  - Combinational from Selector and occupancy: InReady = (Selector==0) ? (Level0<DEPTH) : (Level1<DEPTH).
  - Independent of InValid.
  - Does not account for a same-cycle pop on a full channel: a full channel refuses input even while draining. This is intentional and removes the ready-to-ready combinational path.
- Push: when InValid && InReady at a clk edge, InData is written at the selected channel's write pointer. The pointer advances modulo DEPTH and the level increments.
- Pop: when OutputNValid && OutputNReady at a clk edge, channel N's read pointer advances modulo DEPTH and the level decrements. OutputNReady while the channel is empty is ignored.
- Simultaneous push and pop on the same non-full, non-empty channel: the level is unchanged and both pointers advance.
- Simultaneous push to one channel and pop from the other is fully independent.
- Pushing to an empty channel with OutputNReady=1 in the same cycle does not bypass: the word appears the next cycle.
- Latency: a word accepted at edge k is visible on OutputN with OutputNValid=1 after edge k. Minimum one cycle, no combinational input-to-output path.
- OutputN is the head entry read from registered storage. When the channel is empty, OutputN drives 0, matching the mux's zero default.
- OutputNValid = (LevelN != 0).
- Ordering: FIFO order holds within each channel. There is no ordering guarantee across channels.
- Pointer wrap: at DEPTH-1 the pointer returns to 0. Level never exceeds DEPTH and never underflows.
- A Selector change while InValid=1 and InReady=0 is legal. InReady re-evaluates against the new channel.

Test Plan:
- Reset check: hold reset_n=0 for 2 edges with InValid=1, then release -> Output0Valid=Output1Valid=0, Level0=Level1=0, Output0=Output1=0, and no word captured.
- Basic routing: push 0x11111111 with Selector=0, then 0x22222222 with Selector=1, consumers Ready=1 -> Output0=0x11111111 valid one cycle after its push, Output1=0x22222222 one cycle after its push, each pop returns Level to 0.
- Full and backpressure: Output0Ready=0, push 0xA0,0xA1 to channel 0 -> Level0=2, InReady=0 for Selector=0 while a third word 0xA2 is held. Switch Selector=1 -> InReady=1 and 0xB0 enters channel 1 while channel 0 stays full.
- Drain with ordering: from the full state, raise Output0Ready -> 0xA0 then 0xA1 emerge on consecutive cycles. InReady for channel 0 returns to 1 one edge after the first pop, and 0xA2 is accepted afterwards, preserving order A0, A1, A2.
- Concurrent push and pop plus wrap: stream 8 words to channel 1 with Output1Ready=1 every cycle -> Level1 stays at 1 after the first word, outputs are in order, and pointers wrap at least 3 times with no loss or duplication.
- Reset mid-operation: with Level0=2 and Level1=1, assert reset_n=0 for one edge during a push -> all levels 0, both valids 0, and the pushed word is discarded.
